// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-file write scoreboard for the pipelined core.
// Tracks outstanding writes per architectural register with a small
// saturating counter. Issue stalls on a pending source or a saturated
// destination counter. Register 31 (XZR) is never tracked.
//
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN
//   When defined, a source register whose last outstanding write retires in
//   the same cycle does not stall. This depends on the register file
//   forwarding a write to a read in the same cycle.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rn,
  input  logic [4:0]  issue_rm,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall,
  output logic        issue_accept,
  output logic [31:0] pending,
  output logic        busy,
  output logic        err_underflow
);

  localparam logic [4:0]       XZR     = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q [32];
  logic [CNT_W-1:0] count_d [32];
  logic [31:0]      pending_q, pending_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] cnt_rn, cnt_rm, cnt_rd, cnt_wb;
  logic             src_hz_rn, src_hz_rm, sat_hz, underflow;

  assign cnt_rn = count_q[issue_rn];
  assign cnt_rm = count_q[issue_rm];
  assign cnt_rd = count_q[issue_rd];
  assign cnt_wb = count_q[wb_rd];

  // Hazard detection from the current counts; zero-cycle path to stall.
  always_comb begin
    src_hz_rn = (issue_rn != XZR) && (cnt_rn != '0);
    src_hz_rm = (issue_rm != XZR) && (cnt_rm != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Last outstanding write retiring now is forwarded by the register file.
    if (wb_valid && (wb_rd == issue_rn) && (cnt_rn == CNT_ONE)) src_hz_rn = 1'b0;
    if (wb_valid && (wb_rd == issue_rm) && (cnt_rm == CNT_ONE)) src_hz_rm = 1'b0;
`endif
    // A saturated counter can still take a new write if one retires this cycle.
    sat_hz = issue_wr && (issue_rd != XZR) && (cnt_rd == CNT_MAX) &&
             !(wb_valid && (wb_rd == issue_rd));
    stall        = issue_valid && (src_hz_rn || src_hz_rm || sat_hz);
    issue_accept = issue_valid && !stall && !reset;
  end

  // Next-state counts, pending vector and sticky underflow flag.
  always_comb begin
    count_d   = count_q;
    pending_d = '0;
    underflow = wb_valid && (wb_rd != XZR) && (cnt_wb == '0);
    for (int i = 0; i < 31; i++) begin
      logic inc, dec;
      inc = issue_accept && issue_wr && (issue_rd == 5'(i));
      dec = wb_valid && (wb_rd == 5'(i)) && (count_q[i] != '0);
      count_d[i] = count_q[i] + CNT_W'(inc) - CNT_W'(dec);
    end
    count_d[31] = '0;
    for (int i = 0; i < 32; i++) begin
      pending_d[i] = (count_d[i] != '0);
    end
    busy_d = |pending_d;
    err_d  = err_q || underflow;
  end

  // State registers with synchronous reset that drops all outstanding writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '{default: '0};
      pending_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign pending       = pending_q;
  assign busy          = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed scenarios plus randomized traffic,
// all checked against a counter-array reference model.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk;
  logic        reset;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_rd, issue_rn, issue_rm;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall, issue_accept;
  logic [31:0] pending;
  logic        busy, err_underflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  int cnt [32];
  bit m_err;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_rn     (issue_rn),
    .issue_rm     (issue_rm),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .stall        (stall),
    .issue_accept (issue_accept),
    .pending      (pending),
    .busy         (busy),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_src_hz(int r);
    if (r == 31) return 0;
    if (cnt[r] == 0) return 0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && int'(wb_rd) == r && cnt[r] == 1) return 0;
`endif
    return 1;
  endfunction

  function automatic bit m_stall();
    bit sat;
    if (!issue_valid) return 0;
    sat = issue_wr && issue_rd != 31 && cnt[issue_rd] == MAXC &&
          !(wb_valid && wb_rd == issue_rd);
    return m_src_hz(int'(issue_rn)) || m_src_hz(int'(issue_rm)) || sat;
  endfunction

  function automatic bit m_accept();
    return issue_valid && !m_stall() && !reset;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = (cnt[i] != 0);
    return p;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void m_clock();
    bit acc;
    acc = m_accept();
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      m_err = 0;
      return;
    end
    if (wb_valid && wb_rd != 31) begin
      if (cnt[wb_rd] == 0) m_err = 1;
      else cnt[wb_rd] = cnt[wb_rd] - 1;
    end
    if (acc && issue_wr && issue_rd != 31) cnt[issue_rd] = cnt[issue_rd] + 1;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_in(input bit rst, input bit v, input bit wr, input int rd,
                        input int rn, input int rm, input bit wbv, input int wbr);
    @(negedge clk);
    reset       = rst;
    issue_valid = v;
    issue_wr    = wr;
    issue_rd    = 5'(rd);
    issue_rn    = 5'(rn);
    issue_rm    = 5'(rm);
    wb_valid    = wbv;
    wb_rd       = 5'(wbr);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle_tick();
    set_in(0, 0, 0, 31, 31, 31, 0, 31);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_in(1, 1, 1, 4, 31, 31, 1, 6);
    total++;
    if (issue_accept !== 1'b0) begin
      bad++; $display("FAIL reset_accept: got %b want 0", issue_accept);
    end
    tick();
    total++;
    if (pending !== 32'h0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
      bad++; $display("FAIL reset_state: pending=%h busy=%b err=%b want 0/0/0",
                      pending, busy, err_underflow);
    end
  endtask

  task automatic test_basic_issue();
    set_in(0, 1, 1, 5, 31, 31, 0, 0);
    total++;
    if (issue_accept !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL basic_accept: accept=%b stall=%b want 1/0", issue_accept, stall);
    end
    tick();
    total++;
    if (pending !== m_pending() || pending[5] !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_pending: pending=%h busy=%b want %h/1", pending, busy, m_pending());
    end
  endtask

  task automatic test_src_hazard();
    bit exp_stall;
    set_in(0, 1, 0, 0, 5, 31, 0, 0);
    total++;
    if (stall !== 1'b1 || issue_accept !== 1'b0) begin
      bad++; $display("FAIL src_stall: stall=%b accept=%b want 1/0", stall, issue_accept);
    end
    tick();
    // same source, with the final write-back of r5 in this cycle
    set_in(0, 1, 0, 0, 5, 31, 1, 5);
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_stall = 1'b0;
`else
    exp_stall = 1'b1;
`endif
    total++;
    if (stall !== exp_stall || exp_stall !== m_stall()) begin
      bad++; $display("FAIL src_wb_same_cycle: stall=%b want %b", stall, exp_stall);
    end
    tick();
    total++;
    if (pending[5] !== 1'b0 || pending !== m_pending()) begin
      bad++; $display("FAIL src_retired: pending=%h want %h", pending, m_pending());
    end
    set_in(0, 1, 0, 0, 31, 5, 0, 0);
    total++;
    if (stall !== 1'b0 || issue_accept !== 1'b1) begin
      bad++; $display("FAIL src_next_cycle: stall=%b accept=%b want 0/1", stall, issue_accept);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < MAXC; k++) begin
      set_in(0, 1, 1, 7, 31, 31, 0, 0);
      total++;
      if (issue_accept !== 1'b1) begin
        bad++; $display("FAIL sat_fill%0d: accept=%b want 1", k, issue_accept);
      end
      tick();
    end
    set_in(0, 1, 1, 7, 31, 31, 0, 0);
    total++;
    if (stall !== 1'b1 || issue_accept !== 1'b0) begin
      bad++; $display("FAIL sat_stall: stall=%b accept=%b want 1/0", stall, issue_accept);
    end
    tick();
    set_in(0, 1, 1, 7, 31, 31, 1, 7);
    total++;
    if (stall !== 1'b0 || issue_accept !== 1'b1) begin
      bad++; $display("FAIL sat_with_wb: stall=%b accept=%b want 0/1", stall, issue_accept);
    end
    tick();
    // count must still be saturated
    set_in(0, 1, 1, 7, 31, 31, 0, 0);
    total++;
    if (stall !== 1'b1 || cnt[7] != MAXC) begin
      bad++; $display("FAIL sat_still_full: stall=%b want 1 (model count %0d)", stall, cnt[7]);
    end
    tick();
    for (int k = 0; k < MAXC; k++) begin
      set_in(0, 0, 0, 31, 31, 31, 1, 7);
      tick();
    end
    total++;
    if (pending[7] !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sat_drain: pending=%h busy=%b want 0/0", pending, busy);
    end
  endtask

  task automatic test_xzr();
    set_in(0, 1, 1, 31, 31, 31, 1, 31);
    total++;
    if (issue_accept !== 1'b1) begin
      bad++; $display("FAIL xzr_accept: accept=%b want 1", issue_accept);
    end
    tick();
    total++;
    if (pending !== 32'h0 || err_underflow !== 1'b0) begin
      bad++; $display("FAIL xzr_untracked: pending=%h err=%b want 0/0", pending, err_underflow);
    end
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1, 1, 31, 31, 31, 0, 0);
      tick();
    end
    set_in(0, 1, 0, 0, 31, 31, 0, 0);
    total++;
    if (stall !== 1'b0 || pending !== 32'h0) begin
      bad++; $display("FAIL xzr_src: stall=%b pending=%h want 0/0", stall, pending);
    end
    tick();
  endtask

  task automatic test_underflow();
    set_in(0, 0, 0, 31, 31, 31, 1, 9);
    tick();
    total++;
    if (err_underflow !== 1'b1) begin
      bad++; $display("FAIL underflow_set: err=%b want 1", err_underflow);
    end
    set_in(0, 1, 1, 2, 31, 31, 0, 0); tick();
    set_in(0, 1, 0, 0, 31, 31, 1, 2); tick();
    total++;
    if (err_underflow !== 1'b1 || pending !== m_pending()) begin
      bad++; $display("FAIL underflow_sticky: err=%b pending=%h want 1/%h",
                      err_underflow, pending, m_pending());
    end
    set_in(0, 1, 1, 12, 31, 31, 0, 0); tick();
    set_in(1, 0, 0, 31, 31, 31, 0, 0); tick();
    total++;
    if (err_underflow !== 1'b0 || pending !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL underflow_reset: err=%b pending=%h busy=%b want 0/0/0",
                      err_underflow, pending, busy);
    end
  endtask

  task automatic test_same_cycle_incdec();
    set_in(0, 1, 1, 3, 31, 31, 0, 0); tick();
    set_in(0, 1, 1, 3, 31, 31, 1, 3);
    total++;
    if (issue_accept !== 1'b1) begin
      bad++; $display("FAIL incdec_accept: accept=%b want 1", issue_accept);
    end
    tick();
    total++;
    if (pending[3] !== 1'b1 || cnt[3] != 1) begin
      bad++; $display("FAIL incdec_hold: pending[3]=%b want 1", pending[3]);
    end
    set_in(0, 0, 0, 31, 31, 31, 1, 3); tick();
    total++;
    if (pending[3] !== 1'b0 || err_underflow !== 1'b0) begin
      bad++; $display("FAIL incdec_single: pending[3]=%b err=%b want 0/0", pending[3], err_underflow);
    end
  endtask

  function automatic int rnd_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 31 : r;
  endfunction

  task automatic test_random();
    int errs_before;
    errs_before = bad;
    for (int k = 0; k < 600; k++) begin
      set_in(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), rnd_reg(), rnd_reg(), rnd_reg(),
             ($urandom_range(0, 2) == 0), rnd_reg());
      total++;
      if (stall !== m_stall() || issue_accept !== m_accept()) begin
        bad++; $display("FAIL rand_comb[%0d]: stall=%b accept=%b want %b/%b",
                        k, stall, issue_accept, m_stall(), m_accept());
      end
      tick();
      total++;
      if (pending !== m_pending() || busy !== (m_pending() != 0) || err_underflow !== m_err) begin
        bad++; $display("FAIL rand_state[%0d]: pending=%h busy=%b err=%b want %h/%b/%b",
                        k, pending, busy, err_underflow, m_pending(), (m_pending() != 0), m_err);
      end
      if (bad - errs_before > 10) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    m_err = 0;
    reset = 1'b1; issue_valid = 1'b0; issue_wr = 1'b0;
    issue_rd = '0; issue_rn = '0; issue_rm = '0;
    wb_valid = 1'b0; wb_rd = '0;
    test_reset();
    test_basic_issue();
    test_src_hazard();
    test_saturation();
    test_xzr();
    test_underflow();
    test_same_cycle_incdec();
    test_reset();
    test_random();
    idle_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
